// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon permutation control path.
package ascon_pack;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    WAIT_FINAL,
    FINAL,
    DONE
  } type_fsm_state;

  localparam logic [3:0] ROUND_START_A = 4'd0;
  localparam logic [3:0] ROUND_START_B = 4'd6;
  localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/compteur_round.sv
// 4-bit loadable round counter; init_i has priority over en_i.
module compteur_round (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [3:0] load_i,
  output logic [3:0] cnt_o
);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt_o <= 4'd0;
    end else if (init_i) begin
      cnt_o <= load_i;
    end else if (en_i) begin
      cnt_o <= cnt_o + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Moore sequencer for one Ascon-128 encryption on the shared p-round datapath.
// Define ASCON_CTRL_CYCLE_CNT_EN to add the cycle_cnt_o run-length counter.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_PT_BLOCKS = 4,
  parameter int ROUNDS_A     = 12,
  parameter int ROUNDS_B     = 6
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [3:0]  round_o,
  output logic        en_reg_state_o,
  output logic        init_state_o,
  output logic        en_xor_data_begin_o,
  output logic        en_xor_key_begin_o,
  output logic        en_xor_key_end_o,
  output logic        en_xor_lsb_o,
  output logic        en_cipher_o,
  output logic        en_tag_o,
  output logic [3:0]  block_idx_o,
`ifdef ASCON_CTRL_CYCLE_CNT_EN
  output logic [15:0] cycle_cnt_o,
`endif
  output logic        end_o
);

  // Shorter round budgets start later so every phase still ends on ROUND_LAST.
  localparam logic [3:0] RS_A = ROUND_START_A + 4'(12 - ROUNDS_A);
  localparam logic [3:0] RS_B = ROUND_START_B + 4'(6 - ROUNDS_B);
  localparam logic [3:0] PT_PENULT = 4'(NB_PT_BLOCKS - 2);

  type_fsm_state state, state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_load;
  logic       cnt_init;
  logic       cnt_en;
  logic       last;
  logic       in_round;
  logic       start_ok;
  logic [3:0] block_idx;

  assign last     = (cnt == ROUND_LAST);
  assign in_round = (state == INIT) || (state == AD) ||
                    (state == PT) || (state == FINAL);
  assign cnt_en   = in_round && !last;
  assign start_ok = ((state == IDLE) || (state == DONE)) && start_i;

  compteur_round u_cnt (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .init_i   (cnt_init),
    .en_i     (cnt_en),
    .load_i   (cnt_load),
    .cnt_o    (cnt)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_init = 1'b0;
    cnt_load = RS_A;
    unique case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_n  = INIT;
          cnt_init = 1'b1;
        end
      end
      INIT: if (last) state_n = WAIT_AD;
      WAIT_AD: begin
        if (data_valid_i) begin
          state_n  = AD;
          cnt_init = 1'b1;
          cnt_load = RS_B;
        end
      end
      AD: if (last) state_n = WAIT_PT;
      WAIT_PT: begin
        if (data_valid_i) begin
          state_n  = PT;
          cnt_init = 1'b1;
          cnt_load = RS_B;
        end
      end
      PT: begin
        if (last) begin
          state_n = (block_idx == PT_PENULT) ? WAIT_FINAL : WAIT_PT;
        end
      end
      WAIT_FINAL: begin
        if (data_valid_i) begin
          state_n  = FINAL;
          cnt_init = 1'b1;
        end
      end
      FINAL: if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      block_idx <= 4'd0;
    end else if (start_ok) begin
      block_idx <= 4'd0;
    end else if ((state == PT) && last) begin
      block_idx <= block_idx + 4'd1;
    end
  end

  always_comb begin
    data_ready_o        = 1'b0;
    round_o             = 4'd0;
    en_reg_state_o      = 1'b0;
    init_state_o        = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_o        = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    end_o               = 1'b0;
    unique case (1'b1)
      (state == INIT): begin
        round_o          = cnt;
        en_reg_state_o   = 1'b1;
        init_state_o     = (cnt == RS_A);
        en_xor_key_end_o = last;
      end
      (state == AD): begin
        round_o             = cnt;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (cnt == RS_B);
        en_xor_lsb_o        = last;
      end
      (state == PT): begin
        round_o             = cnt;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (cnt == RS_B);
        en_cipher_o         = (cnt == RS_B);
      end
      (state == FINAL): begin
        round_o             = cnt;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (cnt == RS_A);
        en_xor_key_begin_o  = (cnt == RS_A);
        en_cipher_o         = (cnt == RS_A);
        en_xor_key_end_o    = last;
        en_tag_o            = last;
      end
      (state == WAIT_AD),
      (state == WAIT_PT),
      (state == WAIT_FINAL): data_ready_o = 1'b1;
      (state == DONE): end_o = 1'b1;
      default: ;
    endcase
  end

  assign block_idx_o = block_idx;

`ifdef ASCON_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cycle_cnt_o <= 16'd0;
    end else if (start_ok) begin
      cycle_cnt_o <= 16'd0;
    end else if ((state != IDLE) && (state != DONE) &&
                 (cycle_cnt_o != 16'hFFFF)) begin
      cycle_cnt_o <= cycle_cnt_o + 16'd1;
    end
  end
`endif

endmodule
